xrbus_time_beacon_tx: RTL and testbench

Master-side time-beacon transmitter for XR-BUS. It periodically captures the local time base and applies a signed drift correction. The result is serialized as a 6-word sync frame over a valid/ready stream. Downstream alignment logic at the device, fabric and cloud receivers consumes these frames to recover a common timestamp.

---
 rtl/xrbus_time_beacon_tx.sv | 195 +++++++++++++++++++
 tb/tb_xrbus_time_beacon_tx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xrbus_time_beacon_tx.sv
// XR-BUS master-side time-beacon transmitter.
// An interval counter raises a one-cycle beacon request. On each request
// the local time base plus a signed drift correction is captured and sent
// as a 6-word sync frame over a valid/ready stream:
//   W0 = {A5, seq[7:0]}, W1..W4 = timestamp MSW..LSW, W5 = XOR of W0..W4.
// The stream framing assumes a 16-bit word and at least 8 sequence bits.
module xrbus_time_beacon_tx #(
  parameter int WORD_W = 16,
  parameter int SEQ_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [31:0]       period,
  input  logic [63:0]       time_in,
  input  logic [31:0]       correction,
  input  logic              clr_overrun,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic [SEQ_W-1:0]  seq_num,
  output logic              beacon_sent,
  output logic              overrun
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [2:0] LAST_IDX  = 3'd5;

  // Frame check word: XOR of the header and the four timestamp words.
  function automatic logic [15:0] frame_xor(input logic [7:0]  seq_lo,
                                            input logic [63:0] ts);
    frame_xor = {SYNC_BYTE, seq_lo} ^ ts[63:48] ^ ts[47:32] ^
                ts[31:16] ^ ts[15:0];
  endfunction

  // Word presented at a given frame position.
  function automatic logic [15:0] word_at(input logic [2:0]  idx,
                                          input logic [7:0]  seq_lo,
                                          input logic [63:0] ts);
    case (idx)
      3'd0:    word_at = {SYNC_BYTE, seq_lo};
      3'd1:    word_at = ts[63:48];
      3'd2:    word_at = ts[47:32];
      3'd3:    word_at = ts[31:16];
      3'd4:    word_at = ts[15:0];
      3'd5:    word_at = frame_xor(seq_lo, ts);
      default: word_at = 16'h0000;
    endcase
  endfunction

  state_t             state_r, state_s;
  logic [2:0]         idx_r, idx_s;
  logic [31:0]        cnt_r, cnt_s;
  logic               req_s;
  logic [63:0]        ts_r, ts_s;
  logic [63:0]        capture_s;
  logic [WORD_W-1:0]  tx_data_r, tx_data_s;
  logic               tx_valid_r, tx_valid_s;
  logic               tx_last_r, tx_last_s;
  logic               busy_r;
  logic [SEQ_W-1:0]   seq_num_r, seq_num_s;
  logic               beacon_sent_r, beacon_sent_s;
  logic               overrun_r, overrun_s;
  logic               xfer_s;

  assign capture_s = time_in + {{32{correction[31]}}, correction};
  assign xfer_s    = tx_valid_r & tx_ready;

  // Interval counter: fires once every 'period' cycles while enabled; the
  // >= compare lets a shrunk period fire on the very next cycle.
  always_comb begin
    cnt_s = cnt_r;
    req_s = 1'b0;
    if (enable && (period != 32'd0)) begin
      if (cnt_r >= (period - 32'd1)) begin
        req_s = 1'b1;
        cnt_s = 32'd0;
      end else begin
        cnt_s = cnt_r + 32'd1;
      end
    end else begin
      cnt_s = 32'd0;
    end
  end

  // Frame FSM: next state, next output word and completion bookkeeping.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    ts_s          = ts_r;
    tx_data_s     = tx_data_r;
    tx_valid_s    = tx_valid_r;
    tx_last_s     = tx_last_r;
    seq_num_s     = seq_num_r;
    beacon_sent_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          ts_s       = capture_s;
          state_s    = ST_SEND;
          idx_s      = 3'd0;
          tx_valid_s = 1'b1;
          tx_last_s  = 1'b0;
          tx_data_s  = word_at(3'd0, seq_num_r[7:0], capture_s);
        end else begin
          tx_valid_s = 1'b0;
          tx_last_s  = 1'b0;
        end
      end
      ST_SEND: begin
        if (xfer_s) begin
          if (idx_r == LAST_IDX) begin
            state_s       = ST_IDLE;
            idx_s         = 3'd0;
            tx_valid_s    = 1'b0;
            tx_last_s     = 1'b0;
            tx_data_s     = '0;
            seq_num_s     = seq_num_r + {{(SEQ_W-1){1'b0}}, 1'b1};
            beacon_sent_s = 1'b1;
          end else begin
            idx_s     = idx_r + 3'd1;
            tx_data_s = word_at(idx_r + 3'd1, seq_num_r[7:0], ts_r);
            tx_last_s = (idx_r == (LAST_IDX - 3'd1));
          end
        end else begin
          // Stalled: hold the presented word untouched.
          tx_valid_s = 1'b1;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        idx_s      = 3'd0;
        tx_valid_s = 1'b0;
        tx_last_s  = 1'b0;
      end
    endcase
  end

  // Overrun sticky: a request during a frame sets it and beats a clear.
  always_comb begin
    overrun_s = overrun_r;
    if (req_s && (state_r == ST_SEND)) begin
      overrun_s = 1'b1;
    end else if (clr_overrun) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      idx_r         <= 3'd0;
      cnt_r         <= 32'd0;
      ts_r          <= 64'd0;
      tx_data_r     <= '0;
      tx_valid_r    <= 1'b0;
      tx_last_r     <= 1'b0;
      busy_r        <= 1'b0;
      seq_num_r     <= '0;
      beacon_sent_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
      ts_r          <= ts_s;
      tx_data_r     <= tx_data_s;
      tx_valid_r    <= tx_valid_s;
      tx_last_r     <= tx_last_s;
      busy_r        <= (state_s == ST_SEND);
      seq_num_r     <= seq_num_s;
      beacon_sent_r <= beacon_sent_s;
      overrun_r     <= overrun_s;
    end
  end

  assign tx_data     = tx_data_r;
  assign tx_valid    = tx_valid_r;
  assign tx_last     = tx_last_r;
  assign busy        = busy_r;
  assign seq_num     = seq_num_r;
  assign beacon_sent = beacon_sent_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_xrbus_time_beacon_tx.sv
// Bench for xrbus_time_beacon_tx: directed scenarios plus randomized
// traffic, scored against a frame-level reference model (expected-word
// queue built from the captured timestamp at each predicted request).
module tb_xrbus_time_beacon_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic [63:0] time_in = 64'd0;
  logic [31:0] correction = 32'd0;
  logic        clr_overrun = 1'b0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        tx_last;
  logic        busy;
  logic [15:0] seq_num;
  logic        beacon_sent;
  logic        overrun;

  xrbus_time_beacon_tx #(.WORD_W(16), .SEQ_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
    .time_in(time_in), .correction(correction), .clr_overrun(clr_overrun),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .busy(busy), .seq_num(seq_num),
    .beacon_sent(beacon_sent), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_sent   = 0;

  // Reference model state
  logic [15:0] exp_q[$];
  logic [31:0] m_k   = 32'd0;
  logic [15:0] m_seq = 16'd0;
  logic        m_ov  = 1'b0;
  logic        m_sent = 1'b0;

  // Observation logs
  logic [15:0] got_q[$];
  int          rise_cyc[$];
  logic [15:0] rise_w[$];
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [15:0] pd = 16'd0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Build the six words of a beacon from the captured time and correction.
  task automatic push_frame(input logic [63:0] t, input logic [31:0] c);
    logic signed [63:0] c64;
    logic [63:0]        ts;
    logic [15:0]        w[6];
    c64 = $signed(c);
    ts  = t + c64;
    w[0] = {8'hA5, m_seq[7:0]};
    for (int i = 1; i < 5; i++) w[i] = ts[63 - 16*(i-1) -: 16];
    w[5] = 16'h0000;
    for (int i = 0; i < 5; i++) w[5] = w[5] ^ w[i];
    for (int i = 0; i < 6; i++) exp_q.push_back(w[i]);
  endtask

  // Advance the model by one clock edge using the inputs about to be seen.
  task automatic model_update();
    logic was_busy, req;
    if (!rst_n) begin
      exp_q.delete(); m_k = 32'd0; m_seq = 16'd0; m_ov = 1'b0; m_sent = 1'b0;
      return;
    end
    was_busy = (exp_q.size() != 0);
    req = 1'b0;
    if (enable && period != 32'd0) begin
      if (m_k >= period - 32'd1) begin req = 1'b1; m_k = 32'd0; end
      else m_k = m_k + 32'd1;
    end else m_k = 32'd0;
    m_sent = 1'b0;
    if (was_busy && tx_ready) begin
      if (exp_q.size() == 1) begin m_sent = 1'b1; m_seq = m_seq + 16'd1; end
      void'(exp_q.pop_front());
    end
    if (req && was_busy) m_ov = 1'b1;
    else if (clr_overrun) m_ov = 1'b0;
    if (req && !was_busy) push_frame(time_in, correction);
  endtask

  task automatic compare_all();
    check_val("tx_valid", tx_valid, exp_q.size() != 0);
    check_val("busy", busy, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check_val("tx_data", tx_data, exp_q[0]);
      check_val("tx_last", tx_last, exp_q.size() == 1);
    end
    check_val("seq_num", seq_num, m_seq);
    check_val("beacon_sent", beacon_sent, m_sent);
    check_val("overrun", overrun, m_ov);
    if (pv && !pr && rst_n) begin
      check_val("hold_data", tx_data, pd);
      check_val("hold_last", tx_last, pl);
    end
  endtask

  // One clock: score model, edge, then compare on the falling edge.
  task automatic tick();
    if (tx_valid && tx_ready && rst_n) got_q.push_back(tx_data);
    pv = tx_valid && rst_n; pr = tx_ready; pd = tx_data; pl = tx_last;
    model_update();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (beacon_sent) n_sent++;
    if (tx_valid && !pv) begin rise_cyc.push_back(cyc); rise_w.push_back(tx_data); end
    compare_all();
  endtask

  task automatic run_until_size(input int sz, input string tag);
    int b;
    b = 0;
    while (exp_q.size() != sz && b < 300) begin tick(); b++; end
    if (exp_q.size() != sz) check_val({"timeout_", tag}, exp_q.size(), sz);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_zero"},
              {tx_data, tx_valid, tx_last, busy, seq_num, beacon_sent, overrun},
              '0);
  endtask

  initial begin
    int stall;
    logic was;
    // Reset state
    #1;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic frame
    period = 32'd10; enable = 1'b1; tx_ready = 1'b1;
    time_in = 64'h0000_0001_0000_0000; correction = 32'hFFFF_FFF0;
    got_q.delete(); n_sent = 0;
    run_until_size(6, "basic_start");
    enable = 1'b0;
    run_until_size(0, "basic_end");
    repeat (3) tick();
    check_val("basic_count", got_q.size(), 6);
    if (got_q.size() == 6) begin
      check_val("basic_w0", got_q[0], 16'hA500);
      check_val("basic_w1", got_q[1], 16'h0000);
      check_val("basic_w2", got_q[2], 16'h0000);
      check_val("basic_w3", got_q[3], 16'hFFFF);
      check_val("basic_w4", got_q[4], 16'hFFF0);
      check_val("basic_w5", got_q[5], 16'hA50F);
    end
    check_val("basic_sent", n_sent, 1);
    check_val("basic_seq", seq_num, 16'd1);

    // Periodicity
    rise_cyc.delete(); rise_w.delete();
    period = 32'd20; enable = 1'b1;
    repeat (75) tick();
    enable = 1'b0;
    run_until_size(0, "period_end");
    check_val("period_frames", rise_cyc.size(), 3);
    if (rise_cyc.size() >= 3) begin
      check_val("period_gap1", rise_cyc[1] - rise_cyc[0], 20);
      check_val("period_gap2", rise_cyc[2] - rise_cyc[1], 20);
      check_val("period_w0a", rise_w[0], 16'hA501);
      check_val("period_w0b", rise_w[1], 16'hA502);
      check_val("period_w0c", rise_w[2], 16'hA503);
    end

    // Randomized backpressure and input churn
    stall = 0;
    enable = 1'b1;
    for (int i = 0; i < 800; i++) begin
      time_in = {$urandom, $urandom};
      correction = $urandom;
      if ($urandom_range(0, 30) == 0) period = $urandom_range(1, 30);
      if ($urandom_range(0, 100) == 0) enable = ~enable;
      clr_overrun = ($urandom_range(0, 20) == 0);
      if (stall >= 5) tx_ready = 1'b1;
      else tx_ready = $urandom_range(0, 1);
      if (tx_valid && !tx_ready) stall++; else stall = 0;
      tick();
    end
    clr_overrun = 1'b0; enable = 1'b0; tx_ready = 1'b1;
    run_until_size(0, "random_end");
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;

    // Overrun window
    rise_cyc.delete();
    tick();
    period = 32'd3; enable = 1'b1; tx_ready = 1'b0;
    repeat (8) tick();
    check_val("ovr_set", overrun, 1'b1);
    enable = 1'b0; tx_ready = 1'b1;
    run_until_size(0, "ovr_drain");
    repeat (3) tick();
    check_val("ovr_frames", rise_cyc.size(), 1);
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    check_val("ovr_clear", overrun, 1'b0);
    // Clear coinciding with a fresh overrun: set wins.
    period = 32'd3; enable = 1'b1; tx_ready = 1'b0;
    was = 1'b0;
    for (int i = 0; i < 20 && !was; i++) begin
      if (m_k >= period - 32'd1 && exp_q.size() != 0) begin
        clr_overrun = 1'b1; was = 1'b1;
      end
      tick();
      clr_overrun = 1'b0;
    end
    check_val("ovr_setwins_seen", was, 1'b1);
    check_val("ovr_setwins", overrun, 1'b1);
    enable = 1'b0; tx_ready = 1'b1;
    run_until_size(0, "ovr_end");
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;

    // Sequence wrap and disable mid-frame
    force dut.seq_num_r = 16'hFFFF;
    m_seq = 16'hFFFF;
    tick();
    release dut.seq_num_r;
    tick();
    period = 32'd10; enable = 1'b1; tx_ready = 1'b1;
    run_until_size(6, "wrap_start");
    check_val("wrap_w0", tx_data, 16'hA5FF);
    run_until_size(4, "wrap_mid");
    enable = 1'b0;
    run_until_size(0, "wrap_end");
    check_val("wrap_seq", seq_num, 16'h0000);
    rise_cyc.delete();
    repeat (30) tick();
    check_val("disable_quiet", rise_cyc.size(), 0);

    // Reset mid-frame at W2
    enable = 1'b1; period = 32'd10; tx_ready = 1'b1;
    time_in = 64'h1234_5678_9ABC_DEF0; correction = 32'h0000_0100;
    run_until_size(4, "rst_mid");
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    pv = 1'b0;
    tick();
    rst_n = 1'b1;
    run_until_size(6, "rst_restart");
    check_val("rst_w0", tx_data, 16'hA500);
    enable = 1'b0;
    run_until_size(0, "rst_end");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
